// File: rtl/aq_axis_fifo_pkg.sv
// Shared constants and helpers for the AXI4-Stream synchronous FIFO.
package aq_axis_fifo_pkg;

  // Number of FIFO entries for a given address width.
  function automatic int unsigned fifo_entries(input int unsigned depth);
    return 32'd1 << depth;
  endfunction

endpackage

// File: rtl/aq_axis_fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
import aq_axis_fifo_pkg::*;

module aq_axis_fifo_ram #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 33
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = fifo_entries(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset so the array maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/aq_axis_sync_fifo.sv
// Single-clock AXI4-Stream FIFO with first-word-fall-through output and
// programmable almost-full / almost-empty flags.
import aq_axis_fifo_pkg::*;

module aq_axis_sync_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  RST_N,

  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic                  S_AXIS_TLAST,
  input  logic [FIFO_WIDTH-1:0] S_AXIS_TDATA,
  output logic                  FIFO_WR_FULL,
  output logic                  FIFO_WR_ALM_FULL,
  input  logic [FIFO_DEPTH:0]   FIFO_WR_ALM_COUNT,

  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [FIFO_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic                  FIFO_RD_EMPTY,
  output logic                  FIFO_RD_ALM_EMPTY,
  input  logic [FIFO_DEPTH:0]   FIFO_RD_ALM_COUNT
);

  localparam int unsigned             N       = fifo_entries(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH:0]     N_CNT   = N[FIFO_DEPTH:0];
  localparam logic [FIFO_DEPTH:0]     CNT_ONE = {{FIFO_DEPTH{1'b0}}, 1'b1};
  localparam logic [FIFO_DEPTH-1:0]   PTR_ONE = {{(FIFO_DEPTH-1){1'b0}}, 1'b1};

  logic [FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH:0]   count_q,  count_d;

  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH:0]   ram_wdata;
  logic [FIFO_WIDTH:0]   ram_rdata;
  logic [FIFO_DEPTH+1:0] alm_full_thresh;

  assign wr_en = S_AXIS_TVALID & ~FIFO_WR_FULL;
  assign rd_en = M_AXIS_TREADY & ~FIFO_RD_EMPTY;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ACLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign ram_wdata = {S_AXIS_TLAST, S_AXIS_TDATA};

  aq_axis_fifo_ram #(
    .ADDR_W (FIFO_DEPTH),
    .DATA_W (FIFO_WIDTH + 1)
  ) u_ram (
    .clk_i   (ACLK),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign M_AXIS_TDATA = ram_rdata[FIFO_WIDTH-1:0];
  assign M_AXIS_TLAST = ram_rdata[FIFO_WIDTH];

  assign FIFO_WR_FULL  = (count_q == N_CNT);
  assign FIFO_RD_EMPTY = (count_q == '0);
  assign S_AXIS_TREADY = ~FIFO_WR_FULL;
  assign M_AXIS_TVALID = ~FIFO_RD_EMPTY;

  // Threshold is formed one bit wider so a margin above N wraps negative;
  // that case is forced high explicitly rather than relying on the compare.
  assign alm_full_thresh  = {1'b0, N_CNT} - {1'b0, FIFO_WR_ALM_COUNT};
  assign FIFO_WR_ALM_FULL = (FIFO_WR_ALM_COUNT > N_CNT) |
                            ({1'b0, count_q} >= alm_full_thresh);
  assign FIFO_RD_ALM_EMPTY = (count_q <= FIFO_RD_ALM_COUNT);

endmodule

// File: tb/tb_aq_axis_sync_fifo.sv
// Directed bench for aq_axis_sync_fifo: reset, overfill, drain, concurrent
// traffic, pointer wrap, threshold corner and asynchronous mid-stream reset.
module tb_aq_axis_sync_fifo;

  logic        ACLK = 1'b0;
  logic        RST_N;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;
  logic        S_AXIS_TLAST;
  logic [31:0] S_AXIS_TDATA;
  logic        FIFO_WR_FULL;
  logic        FIFO_WR_ALM_FULL;
  logic [4:0]  FIFO_WR_ALM_COUNT;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        FIFO_RD_EMPTY;
  logic        FIFO_RD_ALM_EMPTY;
  logic [4:0]  FIFO_RD_ALM_COUNT;

  int vectors    = 0;
  int miscompares = 0;

  always #5 ACLK = ~ACLK;

  aq_axis_sync_fifo #(
    .FIFO_DEPTH (4),
    .FIFO_WIDTH (32)
  ) dut (
    .ACLK              (ACLK),
    .RST_N             (RST_N),
    .S_AXIS_TVALID     (S_AXIS_TVALID),
    .S_AXIS_TREADY     (S_AXIS_TREADY),
    .S_AXIS_TLAST      (S_AXIS_TLAST),
    .S_AXIS_TDATA      (S_AXIS_TDATA),
    .FIFO_WR_FULL      (FIFO_WR_FULL),
    .FIFO_WR_ALM_FULL  (FIFO_WR_ALM_FULL),
    .FIFO_WR_ALM_COUNT (FIFO_WR_ALM_COUNT),
    .M_AXIS_TVALID     (M_AXIS_TVALID),
    .M_AXIS_TREADY     (M_AXIS_TREADY),
    .M_AXIS_TDATA      (M_AXIS_TDATA),
    .M_AXIS_TLAST      (M_AXIS_TLAST),
    .FIFO_RD_EMPTY     (FIFO_RD_EMPTY),
    .FIFO_RD_ALM_EMPTY (FIFO_RD_ALM_EMPTY),
    .FIFO_RD_ALM_COUNT (FIFO_RD_ALM_COUNT)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_flags(input string tag, input int cnt, input int alm_full_at, input int alm_empty_le);
    check({tag, ".empty"},    64'(FIFO_RD_EMPTY),     64'(cnt == 0));
    check({tag, ".tvalid"},   64'(M_AXIS_TVALID),     64'(cnt != 0));
    check({tag, ".full"},     64'(FIFO_WR_FULL),      64'(cnt == 16));
    check({tag, ".tready"},   64'(S_AXIS_TREADY),     64'(cnt != 16));
    check({tag, ".almfull"},  64'(FIFO_WR_ALM_FULL),  64'(cnt >= alm_full_at));
    check({tag, ".almempty"}, 64'(FIFO_RD_ALM_EMPTY), 64'(cnt <= alm_empty_le));
  endtask

  initial begin
    logic [31:0] expq[$];
    int cnt;
    int reads;
    logic wr;
    logic rd;

    RST_N             = 1'b0;
    S_AXIS_TVALID     = 1'b0;
    S_AXIS_TLAST      = 1'b0;
    S_AXIS_TDATA      = '0;
    M_AXIS_TREADY     = 1'b0;
    FIFO_WR_ALM_COUNT = 5'd4;
    FIFO_RD_ALM_COUNT = 5'd2;

    // Reset values while held and after release.
    #99;
    check_flags("in_reset", 0, 12, 2);
    #1;
    RST_N = 1'b1;
    step();
    check_flags("post_reset", 0, 12, 2);

    // Overfill with the reader stalled: 16 accepted, 0x10..0x13 dropped.
    for (int i = 0; i < 20; i++) begin
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = 32'(i);
      S_AXIS_TLAST  = i[0];
      step();
      check_flags($sformatf("fill%0d", i), (i + 1 > 16) ? 16 : i + 1, 12, 2);
      check("fill.head", 64'(M_AXIS_TDATA), 64'h0);
    end
    S_AXIS_TVALID = 1'b0;

    // Drain: data appears in order, fall-through, with its TLAST.
    M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d.data", i), 64'(M_AXIS_TDATA), 64'(i));
      check($sformatf("drain%0d.last", i), 64'(M_AXIS_TLAST), 64'(i % 2));
      check_flags($sformatf("drain%0d", i), 16 - i, 12, 2);
      step();
    end
    check_flags("drained", 0, 12, 2);
    step();
    check_flags("ready_while_empty", 0, 12, 2);
    M_AXIS_TREADY = 1'b0;

    // Concurrent traffic; thresholds chosen so both flags pin count at 9.
    FIFO_WR_ALM_COUNT = 5'd7;
    FIFO_RD_ALM_COUNT = 5'd9;
    cnt   = 0;
    reads = 0;
    for (int c = 0; c < 40; c++) begin
      S_AXIS_TVALID = (c < 20);
      S_AXIS_TDATA  = 32'h100 + 32'(c);
      S_AXIS_TLAST  = 1'b0;
      M_AXIS_TREADY = (c >= 9) && (cnt > 0);
      wr = S_AXIS_TVALID && (cnt < 16);
      rd = M_AXIS_TREADY && (cnt > 0);
      if (rd) begin
        check($sformatf("conc_rd%0d", reads), 64'(M_AXIS_TDATA), 64'(expq[0]));
        void'(expq.pop_front());
        reads++;
      end
      if (wr) expq.push_back(S_AXIS_TDATA);
      cnt = cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
      step();
      if (c == 9 || c == 15 || c == 19 || c == 39)
        check_flags($sformatf("conc%0d", c), cnt, 9, 9);
    end
    check("conc.reads", 64'(reads), 64'd20);
    S_AXIS_TVALID = 1'b0;
    M_AXIS_TREADY = 1'b0;
    FIFO_WR_ALM_COUNT = 5'd4;
    FIFO_RD_ALM_COUNT = 5'd2;

    // Margin beyond capacity forces almost-full even when empty.
    FIFO_WR_ALM_COUNT = 5'd17;
    #1;
    check("almfull_over_n", 64'(FIFO_WR_ALM_FULL), 64'd1);
    FIFO_WR_ALM_COUNT = 5'd4;
    #1;
    check("almfull_restore", 64'(FIFO_WR_ALM_FULL), 64'd0);

    // Wrapped pointers: single word with TLAST.
    step();
    check("wrap.pre_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = 32'hA5A5A5A5;
    S_AXIS_TLAST  = 1'b1;
    step();
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    check("wrap.tvalid", 64'(M_AXIS_TVALID), 64'd1);
    check("wrap.data",   64'(M_AXIS_TDATA),  64'hA5A5A5A5);
    check("wrap.last",   64'(M_AXIS_TLAST),  64'd1);
    M_AXIS_TREADY = 1'b1;
    step();
    M_AXIS_TREADY = 1'b0;
    check_flags("wrap.drained", 0, 12, 2);

    // Asynchronous reset with five entries stored.
    for (int i = 0; i < 5; i++) begin
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = 32'h200 + 32'(i);
      step();
    end
    S_AXIS_TVALID = 1'b0;
    check_flags("pre_rst", 5, 12, 2);
    #2;
    RST_N = 1'b0;
    #1;
    check_flags("async_rst", 0, 12, 2);
    step();
    step();
    @(negedge ACLK);
    RST_N = 1'b1;
    step();
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = 32'h300;
    step();
    S_AXIS_TDATA  = 32'h301;
    step();
    S_AXIS_TVALID = 1'b0;
    check("after_rst.first", 64'(M_AXIS_TDATA), 64'h300);
    check_flags("after_rst", 2, 12, 2);
    M_AXIS_TREADY = 1'b1;
    step();
    check("after_rst.second", 64'(M_AXIS_TDATA), 64'h301);
    step();
    M_AXIS_TREADY = 1'b0;
    check_flags("after_rst.empty", 0, 12, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
